fetch_prefetch_unit: RTL and testbench

Sequential, parametrised instruction fetch stage. It owns the fetch PC and issues word reads over the standard memory-interface signal group using a ready handshake, with at most one request outstanding. Returned words and their PCs are buffered in a DEPTH-entry instruction queue that feeds decode through a valid/ready handshake. Jump/branch redirects, sourced from the Branch Unit and Address Generator, flush the queue and discard any stale in-flight response.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_prefetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic       READ           = 1'b0;
  localparam logic       WRITE          = 1'b1;
  localparam logic [3:0] FULL_WORD_MASK = 4'b1111;
  localparam int unsigned PC_INCREMENT  = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {PC, word} pairs between fetch and decode.
// Flush empties the queue in one cycle and overrides push/pop.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_COUNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// and buffers returned words for decode. Redirects flush the queue and drop
// any response still in flight.
// Optional FETCH_BYPASS_EN: an accepted response is presented to decode in the
// same cycle when the queue is empty.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     DEPTH         = 4,
  parameter logic [XLEN-1:0] RESET_ADDRESS = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     jump_branch_enable,
  input  logic [XLEN-1:0]          address,
  output logic                     memory_interface_enable,
  output logic                     memory_interface_memory_state,
  output logic [XLEN-1:0]          memory_interface_address,
  output logic [3:0]               memory_interface_frame_mask,
  input  logic                     memory_interface_ready,
  input  logic [XLEN-1:0]          memory_interface_data,
  output logic                     instruction_valid,
  output logic [XLEN-1:0]          instruction,
  output logic [XLEN-1:0]          instruction_PC,
  input  logic                     instruction_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   resume_pc;
  logic [2*XLEN-1:0] q_out;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     occ_after;
  logic              q_empty;
  logic              q_full;
  logic              accept;
  logic              bypass_take;
  logic              push;
  logic              pop;
  logic              space_after;

  assign memory_interface_memory_state = READ;
  assign memory_interface_frame_mask   = FULL_WORD_MASK;
  assign queue_count                   = q_count;

  assign target    = address & ~XLEN'(3);
  assign accept    = (state == REQUEST) && memory_interface_ready && !jump_branch_enable;
  assign next_pc   = jump_branch_enable ? target : fetch_pc + XLEN'(PC_INCREMENT);
  assign resume_pc = jump_branch_enable ? target : fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign bypass_take = accept && q_empty && instruction_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = accept && !bypass_take && (!q_full || pop);
  assign pop  = instruction_ready && !q_empty;

  // Occupancy as it will be after this cycle's flush/push/pop.
  always_comb begin
    occ_after = q_count;
    if (jump_branch_enable)  occ_after = '0;
    else if (push && !pop)   occ_after = q_count + 1'b1;
    else if (pop && !push)   occ_after = q_count - 1'b1;
  end
  assign space_after = (occ_after < DEPTH_COUNT);

  fetch_queue #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (jump_branch_enable),
    .data_in  ({memory_interface_address, memory_interface_data}),
    .data_out (q_out),
    .count    (q_count),
    .empty    (q_empty),
    .full     (q_full)
  );

  // Decode-facing head; the bypass path shows an accepted response directly.
  always_comb begin
    instruction_valid = !q_empty;
    instruction       = q_empty ? '0 : q_out[XLEN-1:0];
    instruction_PC    = q_empty ? '0 : q_out[2*XLEN-1:XLEN];
`ifdef FETCH_BYPASS_EN
    if (q_empty && accept) begin
      instruction_valid = 1'b1;
      instruction       = memory_interface_data;
      instruction_PC    = memory_interface_address;
    end
`endif
  end

  // Request FSM; address/enable are held until the ready cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= IDLE;
      fetch_pc                 <= RESET_ADDRESS;
      memory_interface_enable  <= 1'b0;
      memory_interface_address <= RESET_ADDRESS;
    end else begin
      case (state)
        IDLE: begin
          fetch_pc <= resume_pc;
          if (enable && (jump_branch_enable || q_count < DEPTH_COUNT)) begin
            memory_interface_enable  <= 1'b1;
            memory_interface_address <= resume_pc;
            state                    <= REQUEST;
          end
        end
        REQUEST: begin
          if (memory_interface_ready) begin
            fetch_pc <= next_pc;
            if (enable && space_after) begin
              memory_interface_address <= next_pc;
            end else begin
              memory_interface_enable <= 1'b0;
              state                   <= IDLE;
            end
          end else if (jump_branch_enable) begin
            fetch_pc <= target;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          fetch_pc <= resume_pc;
          if (memory_interface_ready) begin
            if (enable && space_after) begin
              memory_interface_address <= resume_pc;
              state                    <= REQUEST;
            end else begin
              memory_interface_enable <= 1'b0;
              state                   <= IDLE;
            end
          end
        end
        default: begin
          memory_interface_enable <= 1'b0;
          state                   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit (honours FETCH_BYPASS_EN).
module tb_fetch_prefetch_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        jump_branch_enable;
  logic [31:0] address;
  logic        memory_interface_enable;
  logic        memory_interface_memory_state;
  logic [31:0] memory_interface_address;
  logic [3:0]  memory_interface_frame_mask;
  logic        memory_interface_ready;
  logic [31:0] memory_interface_data;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instruction_PC;
  logic        instruction_ready;
  logic [2:0]  queue_count;

  int errors = 0;
  int checks = 0;

  fetch_prefetch_unit #(
    .XLEN          (XLEN),
    .DEPTH         (DEPTH),
    .RESET_ADDRESS (RESET_ADDRESS)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .enable                        (enable),
    .jump_branch_enable            (jump_branch_enable),
    .address                       (address),
    .memory_interface_enable       (memory_interface_enable),
    .memory_interface_memory_state (memory_interface_memory_state),
    .memory_interface_address      (memory_interface_address),
    .memory_interface_frame_mask   (memory_interface_frame_mask),
    .memory_interface_ready        (memory_interface_ready),
    .memory_interface_data         (memory_interface_data),
    .instruction_valid             (instruction_valid),
    .instruction                   (instruction),
    .instruction_PC                (instruction_PC),
    .instruction_ready             (instruction_ready),
    .queue_count                   (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of fetched {pc, word} pairs plus the
  // outstanding-request view (active, address, whether its data is stale).
  logic [63:0] mq[$];
  bit          m_active;
  bit          m_stale;
  logic [31:0] m_addr;
  logic [31:0] m_next_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0093} ^ {16'h0000, a[31:16]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active  = 0;
    m_stale   = 0;
    m_addr    = RESET_ADDRESS;
    m_next_pc = RESET_ADDRESS;
  endtask

  task automatic model_clock();
    logic [31:0] tgt;
    int          size0;
    bit          good;
    bit          consumed;
    if (reset) begin
      model_reset();
      return;
    end
    tgt      = address & ~32'h3;
    size0    = mq.size();
    good     = m_active && memory_interface_ready && !m_stale && !jump_branch_enable;
    consumed = 0;
`ifdef FETCH_BYPASS_EN
    consumed = good && (size0 == 0) && instruction_ready;
`endif
    if (jump_branch_enable) mq.delete();
    else begin
      if (size0 > 0 && instruction_ready) void'(mq.pop_front());
      if (good && !consumed) mq.push_back({m_addr, memory_interface_data});
    end
    if (jump_branch_enable) m_next_pc = tgt;
    else if (good)          m_next_pc = m_addr + 32'd4;
    if (!m_active) begin
      if (enable && (jump_branch_enable || size0 < DEPTH)) begin
        m_active = 1; m_stale = 0; m_addr = m_next_pc;
      end
    end else if (!memory_interface_ready) begin
      if (jump_branch_enable) m_stale = 1;
    end else if (enable && mq.size() < DEPTH) begin
      m_stale = 0; m_addr = m_next_pc;
    end else begin
      m_active = 0;
    end
  endtask

  function automatic logic [100:0] expected();
    logic        v;
    logic [31:0] w, p;
    v = 0; w = '0; p = '0;
    if (mq.size() > 0) begin
      v = 1; {p, w} = mq[0];
    end
`ifdef FETCH_BYPASS_EN
    if (mq.size() == 0 && m_active && !m_stale && memory_interface_ready && !jump_branch_enable) begin
      v = 1; w = memory_interface_data; p = m_addr;
    end
`endif
    return {m_active, m_addr, v, w, p, 3'(mq.size())};
  endfunction

  function automatic logic [100:0] observed();
    return {memory_interface_enable, memory_interface_address, instruction_valid,
            instruction, instruction_PC, queue_count};
  endfunction

  task automatic apply(input logic rst, input logic en, input logic jb,
                       input logic [31:0] tgt, input logic rdy, input logic irdy);
    reset                  = rst;
    enable                 = en;
    jump_branch_enable     = jb;
    address                = tgt;
    memory_interface_ready = rdy;
    instruction_ready      = irdy;
    memory_interface_data  = mem_word(memory_interface_address);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, '0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    apply(1, 0, 0, '0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (observed() !== {1'b0, RESET_ADDRESS, 1'b0, 32'h0, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", observed(),
               {1'b0, RESET_ADDRESS, 1'b0, 32'h0, 32'h0, 3'd0});
    end
    checks++;
    if (memory_interface_memory_state !== 1'b0 || memory_interface_frame_mask !== 4'hF) begin
      errors++;
      $display("FAIL constant_outputs: got state=%b mask=%h expected state=0 mask=f",
               memory_interface_memory_state, memory_interface_frame_mask);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 2)       apply(0, 1, 0, '0, 0, 0);
      else if (i == 2) apply(1, 1, 0, '0, 0, 0);
      else             apply(0, 0, 0, '0, 1, 1);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL reset_abort cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (i >= 3) begin
        checks++;
        if (memory_interface_enable !== 1'b0 || queue_count !== 3'd0 || instruction_valid !== 1'b0) begin
          errors++;
          $display("FAIL late_ready_idle cycle %0d: got en=%b count=%0d valid=%b expected 0 0 0",
                   i, memory_interface_enable, queue_count, instruction_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    logic [31:0] reqs[$];
    logic [31:0] pcs[$];
    int first_req;
    int first_valid;
    int exp_latency;
    first_req = -1;
    first_valid = -1;
`ifdef FETCH_BYPASS_EN
    exp_latency = 0;
`else
    exp_latency = 1;
`endif
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 0, '0, 1, 1);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL streaming cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (memory_interface_enable && memory_interface_ready) reqs.push_back(memory_interface_address);
      if (instruction_valid && instruction_ready) pcs.push_back(instruction_PC);
      if (memory_interface_enable && first_req < 0) first_req = i;
      if (instruction_valid && first_valid < 0) first_valid = i;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (reqs.size() <= k) begin
        errors++;
        $display("FAIL stream_req_order %0d: got none expected %h", k, 32'(4*k));
      end else if (reqs[k] !== 32'(4*k)) begin
        errors++;
        $display("FAIL stream_req_order %0d: got %h expected %h", k, reqs[k], 32'(4*k));
      end
      checks++;
      if (pcs.size() <= k) begin
        errors++;
        $display("FAIL stream_decode_pc %0d: got none expected %h", k, 32'(4*k));
      end else if (pcs[k] !== 32'(4*k)) begin
        errors++;
        $display("FAIL stream_decode_pc %0d: got %h expected %h", k, pcs[k], 32'(4*k));
      end
    end
    checks++;
    if (first_req < 0 || first_valid - first_req != exp_latency) begin
      errors++;
      $display("FAIL first_word_latency: got %0d expected %0d", first_valid - first_req, exp_latency);
    end
  endtask

  task automatic test_backpressure();
    int max_count;
    max_count = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 0, '0, 1, (i >= 10));
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (int'(queue_count) > max_count) max_count = int'(queue_count);
      if (i == 9) begin
        checks++;
        if (queue_count !== 3'd4 || memory_interface_enable !== 1'b0) begin
          errors++;
          $display("FAIL queue_full_hold: got count=%0d en=%b expected count=4 en=0",
                   queue_count, memory_interface_enable);
        end
      end
      tick();
    end
    checks++;
    if (max_count > 4) begin
      errors++;
      $display("FAIL occupancy_bound: got %0d expected at most 4", max_count);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      apply(0, 1, 1, 32'h10, 0, 0);
      else if (i == 4) apply(0, 1, 0, '0, 1, 0);
      else             apply(0, 1, 0, '0, 0, 0);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL wait_states cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (memory_interface_enable !== 1'b1 || memory_interface_address !== 32'h10) begin
          errors++;
          $display("FAIL request_hold cycle %0d: got en=%b addr=%h expected en=1 addr=00000010",
                   i, memory_interface_enable, memory_interface_address);
        end
      end
      if (i == 5) begin
        checks++;
        if (instruction_valid !== 1'b1 || instruction !== 32'h0010_0093 || instruction_PC !== 32'h10) begin
          errors++;
          $display("FAIL held_word: got v=%b %h pc=%h expected v=1 00100093 pc=00000010",
                   instruction_valid, instruction, instruction_PC);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_pending();
    logic [31:0] reqs[$];
    bit found;
    found = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      apply(0, 1, 0, '0, (memory_interface_address != 32'h18), 1);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL redir_pending_setup cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (memory_interface_enable && memory_interface_address == 32'h18) found = 1;
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_0x18: got timeout expected request at 00000018");
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      apply(0, 1, 1, 32'h200, 0, 1);
      else if (i == 1) apply(0, 1, 0, '0, 0, 1);
      else             apply(0, 1, 0, '0, 1, 1);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL redir_pending cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (i == 1) begin
        checks++;
        if (instruction_valid !== 1'b0 || queue_count !== 3'd0 ||
            memory_interface_enable !== 1'b1 || memory_interface_address !== 32'h18) begin
          errors++;
          $display("FAIL discard_hold: got v=%b count=%0d en=%b addr=%h expected 0 0 1 00000018",
                   instruction_valid, queue_count, memory_interface_enable, memory_interface_address);
        end
      end
      if (i >= 3 && memory_interface_enable && memory_interface_ready) reqs.push_back(memory_interface_address);
      tick();
    end
    checks++;
    if (reqs.size() < 2 || reqs[0] !== 32'h200 || reqs[1] !== 32'h204) begin
      errors++;
      $display("FAIL redirect_target_seq: got %0d reqs first=%h expected 00000200 then 00000204",
               reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_ready();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4)       apply(0, 1, 0, '0, 1, 1);
      else if (i == 4) apply(0, 1, 1, 32'h103, 1, 1);
      else             apply(0, 1, 0, '0, 0, 1);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL redir_ready cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (i == 5) begin
        checks++;
        if (instruction_valid !== 1'b0 || queue_count !== 3'd0 ||
            memory_interface_enable !== 1'b1 || memory_interface_address !== 32'h100) begin
          errors++;
          $display("FAIL redirect_with_ready: got v=%b count=%0d en=%b addr=%h expected 0 0 1 00000100",
                   instruction_valid, queue_count, memory_interface_enable, memory_interface_address);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      apply(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
      else if (i == 1) apply(0, 1, 0, '0, 1, 0);
      else             apply(0, 1, 0, '0, 0, 0);
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL wrap cycle %0d: got %h expected %h", i, observed(), expected());
      end
      if (i == 2) begin
        checks++;
        if (memory_interface_enable !== 1'b1 || memory_interface_address !== 32'h0 ||
            instruction_PC !== 32'hFFFF_FFFC) begin
          errors++;
          $display("FAIL pc_wrap: got en=%b addr=%h pc=%h expected 1 00000000 fffffffc",
                   memory_interface_enable, memory_interface_address, instruction_PC);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      apply(($urandom_range(0, 127) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) != 0));
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, observed(), expected());
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    apply(1, 0, 0, '0, 0, 0);
    test_reset();
    test_reset_abort();
    test_streaming();
    test_backpressure();
    test_wait_states();
    test_redirect_pending();
    test_redirect_ready();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
